// File: rtl/shift_exec_stage_pkg.sv
// Shared widths and operation encodings for the shift/rotate execute slice.
package shift_exec_stage_pkg;

   localparam int DW = 16;
   localparam int RW = 4;
   localparam int AW = 4;

   typedef enum logic [1:0] {
      SHIFT_SLL  = 2'b00,
      SHIFT_SRA  = 2'b01,
      SHIFT_ROR  = 2'b10,
      SHIFT_PASS = 2'b11
   } shift_op_e;

endpackage

// File: rtl/shift_exec_stage_if.sv
// Upstream (ID) and downstream (MEM/WB) handshake bundle of the shift stage.
interface shift_exec_stage_if;
   import shift_exec_stage_pkg::*;

   logic            in_valid;
   logic            in_ready;
   shift_op_e       in_op;
   logic [DW-1:0]   in_src;
   logic [AW-1:0]   in_amt;
   logic [RW-1:0]   in_rd;

   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_result;
   logic [RW-1:0]   out_rd;
   logic            out_z;
   logic            out_n;

   modport master (
      output in_valid, in_op, in_src, in_amt, in_rd, out_ready,
      input  in_ready, out_valid, out_result, out_rd, out_z, out_n
   );

   modport slave (
      input  in_valid, in_op, in_src, in_amt, in_rd, out_ready,
      output in_ready, out_valid, out_result, out_rd, out_z, out_n
   );

endinterface

// File: rtl/shift_exec_stage_ror.sv
// 16-bit combinational rotate-right unit shared by every shift operation.
module ror
   import shift_exec_stage_pkg::*;
(
   input  logic [DW-1:0] data_i,
   input  logic [AW-1:0] amt_i,
   output logic [DW-1:0] data_o
);

   logic [2*DW-1:0] dbl;

   assign dbl    = {data_i, data_i} >> amt_i;
   assign data_o = dbl[DW-1:0];

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage shift/rotate execute slice: S1 holds decoded operands, S2 holds the
// fixed-up result and flags. A single rotator serves SLL, SRA and ROR.
module shift_exec_stage
   import shift_exec_stage_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   shift_exec_stage_if.slave    bus
);

   logic            s1_valid_q, s1_valid_d;
   shift_op_e       s1_op_q,    s1_op_d;
   logic [DW-1:0]   s1_src_q,   s1_src_d;
   logic [AW-1:0]   s1_amt_q,   s1_amt_d;
   logic [RW-1:0]   s1_rd_q,    s1_rd_d;

   logic            s2_valid_q, s2_valid_d;
   logic [DW-1:0]   s2_result_q, s2_result_d;
   logic [RW-1:0]   s2_rd_q,    s2_rd_d;
   logic            s2_z_q,     s2_z_d;
   logic            s2_n_q,     s2_n_d;

   logic            adv1, adv2, accept;
   logic [AW-1:0]   rot_amt;
   logic [DW-1:0]   rot_val;
   logic [DW-1:0]   lo_mask, hi_mask;
   logic [DW-1:0]   result;

   assign adv2         = !s2_valid_q | bus.out_ready;
   assign adv1         = !s1_valid_q | adv2;
   assign accept       = bus.in_valid & adv1;
   assign bus.in_ready = adv1;

   // SLL is a right rotate by (16 - n) mod 16 followed by clearing the wrapped low bits
   always_comb begin
      rot_amt = s1_amt_q;
      case (s1_op_q)
         SHIFT_SLL:  rot_amt = AW'(4'd0 - s1_amt_q);
         SHIFT_PASS: rot_amt = '0;
         default:    rot_amt = s1_amt_q;
      endcase
   end

   ror u_ror (
      .data_i (s1_src_q),
      .amt_i  (rot_amt),
      .data_o (rot_val)
   );

   assign lo_mask = {DW{1'b1}} << s1_amt_q;
   assign hi_mask = ~({DW{1'b1}} >> s1_amt_q);

   always_comb begin
      result = s1_src_q;
      case (s1_op_q)
         SHIFT_SLL:  result = rot_val & lo_mask;
         SHIFT_SRA:  result = s1_src_q[DW-1] ? (rot_val | hi_mask) : (rot_val & ~hi_mask);
         SHIFT_ROR:  result = rot_val;
         SHIFT_PASS: result = s1_src_q;
         default:    result = s1_src_q;
      endcase
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_src_d    = s1_src_q;
      s1_amt_d    = s1_amt_q;
      s1_rd_d     = s1_rd_q;
      s2_valid_d  = s2_valid_q;
      s2_result_d = s2_result_q;
      s2_rd_d     = s2_rd_q;
      s2_z_d      = s2_z_q;
      s2_n_d      = s2_n_q;

      if (adv1) begin
         s1_valid_d = bus.in_valid;
      end
      if (accept) begin
         s1_op_d  = bus.in_op;
         s1_src_d = bus.in_src;
         s1_amt_d = bus.in_amt;
         s1_rd_d  = bus.in_rd;
      end

      // Data only moves when a real beat arrives, so idle outputs stay put
      if (adv2) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_result_d = result;
            s2_rd_d     = s1_rd_q;
            s2_z_d      = (result == '0);
            s2_n_d      = result[DW-1];
         end
      end

      if (flush) begin
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= SHIFT_SLL;
         s1_src_q    <= '0;
         s1_amt_q    <= '0;
         s1_rd_q     <= '0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_rd_q     <= '0;
         s2_z_q      <= 1'b0;
         s2_n_q      <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_src_q    <= s1_src_d;
         s1_amt_q    <= s1_amt_d;
         s1_rd_q     <= s1_rd_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_rd_q     <= s2_rd_d;
         s2_z_q      <= s2_z_d;
         s2_n_q      <= s2_n_d;
      end
   end

   assign bus.out_valid  = s2_valid_q;
   assign bus.out_result = s2_result_q;
   assign bus.out_rd     = s2_rd_q;
   assign bus.out_z      = s2_z_q;
   assign bus.out_n      = s2_n_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage: per-op results, stalls, flush and reset.
module tb_shift_exec_stage;
   import shift_exec_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   shift_exec_stage_if bus ();

   shift_exec_stage dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   task automatic run_single(input shift_op_e op, input logic [15:0] src, input logic [3:0] amt,
                             input logic [3:0] rd, output logic [15:0] res, output logic [3:0] rdo,
                             output logic z, output logic n, output int lat);
      @(negedge clk);
      bus.in_op     = op;
      bus.in_src    = src;
      bus.in_amt    = amt;
      bus.in_rd     = rd;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      res = bus.out_result;
      rdo = bus.out_rd;
      z   = bus.out_z;
      n   = bus.out_n;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = SHIFT_PASS;
      bus.in_src    = '0;
      bus.in_amt    = '0;
      bus.in_rd     = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
      n_total++; if (bus.out_result !== 16'h0000) $display("FAIL reset_out_result got %h want 0000", bus.out_result); else n_pass++;
      n_total++; if (bus.out_rd !== 4'h0) $display("FAIL reset_out_rd got %h want 0", bus.out_rd); else n_pass++;
      n_total++; if ({bus.out_z, bus.out_n} !== 2'b00) $display("FAIL reset_flags got %b want 00", {bus.out_z, bus.out_n}); else n_pass++;
      n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
   endtask

   task automatic test_ror();
      logic [15:0] res; logic [3:0] rdo; logic z, n; int lat;
      run_single(SHIFT_ROR, 16'h1234, 4'd4, 4'd3, res, rdo, z, n, lat);
      n_total++; if (lat !== 2) $display("FAIL ror_latency got %0d want 2", lat); else n_pass++;
      n_total++; if (res !== 16'h4123) $display("FAIL ror_result got %h want 4123", res); else n_pass++;
      n_total++; if (rdo !== 4'd3) $display("FAIL ror_rd got %0d want 3", rdo); else n_pass++;
      n_total++; if ({z, n} !== 2'b00) $display("FAIL ror_flags got %b want 00", {z, n}); else n_pass++;
   endtask

   task automatic test_sll();
      logic [15:0] res; logic [3:0] rdo; logic z, n; int lat;
      run_single(SHIFT_SLL, 16'h8001, 4'd1, 4'd5, res, rdo, z, n, lat);
      n_total++; if (res !== 16'h0002) $display("FAIL sll_8001 got %h want 0002", res); else n_pass++;
      n_total++; if ({z, n} !== 2'b00) $display("FAIL sll_8001_flags got %b want 00", {z, n}); else n_pass++;
      run_single(SHIFT_SLL, 16'h8000, 4'd1, 4'd6, res, rdo, z, n, lat);
      n_total++; if (res !== 16'h0000) $display("FAIL sll_8000 got %h want 0000", res); else n_pass++;
      n_total++; if (z !== 1'b1) $display("FAIL sll_8000_z got %b want 1", z); else n_pass++;
      run_single(SHIFT_SLL, 16'h0001, 4'd15, 4'd7, res, rdo, z, n, lat);
      n_total++; if ({res, n} !== {16'h8000, 1'b1}) $display("FAIL sll_amt15 got %h/%b want 8000/1", res, n); else n_pass++;
   endtask

   task automatic test_sra();
      logic [15:0] res; logic [3:0] rdo; logic z, n; int lat;
      run_single(SHIFT_SRA, 16'h8000, 4'd15, 4'd1, res, rdo, z, n, lat);
      n_total++; if (res !== 16'hFFFF) $display("FAIL sra_8000_15 got %h want ffff", res); else n_pass++;
      n_total++; if (n !== 1'b1) $display("FAIL sra_8000_15_n got %b want 1", n); else n_pass++;
      run_single(SHIFT_SRA, 16'h7F00, 4'd4, 4'd2, res, rdo, z, n, lat);
      n_total++; if (res !== 16'h07F0) $display("FAIL sra_7f00_4 got %h want 07f0", res); else n_pass++;
      n_total++; if (n !== 1'b0) $display("FAIL sra_7f00_4_n got %b want 0", n); else n_pass++;
      run_single(SHIFT_SRA, 16'h9235, 4'd4, 4'd2, res, rdo, z, n, lat);
      n_total++; if (res !== 16'hF923) $display("FAIL sra_9235_4 got %h want f923", res); else n_pass++;
   endtask

   task automatic test_amt0();
      shift_op_e ops[4] = '{SHIFT_SLL, SHIFT_SRA, SHIFT_ROR, SHIFT_PASS};
      logic [15:0] res; logic [3:0] rdo; logic z, n; int lat;
      for (int i = 0; i < 4; i++) begin
         run_single(ops[i], 16'hA5C3, 4'd0, 4'(i), res, rdo, z, n, lat);
         n_total++;
         if ({res, z, n} !== {16'hA5C3, 1'b0, 1'b1})
            $display("FAIL amt0_op%0d got %h z=%b n=%b want a5c3 z=0 n=1", i, res, z, n);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      shift_op_e   ops[4]  = '{SHIFT_ROR, SHIFT_SLL, SHIFT_SRA, SHIFT_PASS};
      logic [15:0] srcs[4] = '{16'h1234, 16'h0001, 16'h8000, 16'hBEEF};
      logic [3:0]  amts[4] = '{4'd4, 4'd3, 4'd1, 4'd9};
      logic [15:0] exps[4] = '{16'h4123, 16'h0008, 16'hC000, 16'hBEEF};
      int sent = 0, got = 0, stall_left = 3, cyc = 0;
      bit seen_first = 0, saw_block = 0, have_held = 0;
      logic [15:0] held_res; logic [3:0] held_rd;
      while (got < 4 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (sent < 4) begin
            bus.in_op    = ops[sent];
            bus.in_src   = srcs[sent];
            bus.in_amt   = amts[sent];
            bus.in_rd    = 4'(sent + 8);
            bus.in_valid = 1'b1;
         end else bus.in_valid = 1'b0;
         if (bus.out_valid === 1'b1) seen_first = 1;
         bus.out_ready = !(seen_first && stall_left > 0);
         #1;
         if (!bus.out_ready) begin
            if (bus.in_ready === 1'b0) saw_block = 1;
            if (!have_held) begin
               held_res = bus.out_result; held_rd = bus.out_rd; have_held = 1;
            end else begin
               n_total++; if (bus.out_result !== held_res) $display("FAIL b2b_stall_result got %h want %h", bus.out_result, held_res); else n_pass++;
               n_total++; if (bus.out_rd !== held_rd) $display("FAIL b2b_stall_rd got %h want %h", bus.out_rd, held_rd); else n_pass++;
            end
            stall_left--;
         end
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            n_total++;
            if ({bus.out_result, bus.out_rd} !== {exps[got], 4'(got + 8)})
               $display("FAIL b2b_beat%0d got %h/%0d want %h/%0d", got, bus.out_result, bus.out_rd, exps[got], got + 8);
            else n_pass++;
            got++;
         end
         if (bus.in_valid && bus.in_ready === 1'b1) sent++;
      end
      n_total++; if (got !== 4) $display("FAIL b2b_count got %0d want 4", got); else n_pass++;
      n_total++; if (saw_block !== 1'b1) $display("FAIL b2b_in_ready_low got %b want 1", saw_block); else n_pass++;
      bus.in_valid = 1'b0;
      @(negedge clk);
      n_total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_no_dup got %b want 0", bus.out_valid); else n_pass++;
   endtask

   task automatic test_flush();
      logic [15:0] res; logic [3:0] rdo; logic z, n; int lat;
      bit leaked = 0;
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_op = SHIFT_PASS; bus.in_amt = 4'd0;
      bus.in_src = 16'h1111; bus.in_rd = 4'd1; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_src = 16'h2222; bus.in_rd = 4'd2;
      @(negedge clk);
      bus.in_src = 16'h3333; bus.in_rd = 4'd3; flush = 1'b1;
      #1;
      n_total++; if (bus.out_valid !== 1'b1) $display("FAIL flush_prefull got %b want 1", bus.out_valid); else n_pass++;
      @(negedge clk);
      flush = 1'b0; bus.in_valid = 1'b0;
      n_total++; if (bus.out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", bus.out_valid); else n_pass++;
      bus.out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) leaked = 1;
      end
      n_total++; if (leaked !== 1'b0) $display("FAIL flush_leak got %b want 0", leaked); else n_pass++;
      run_single(SHIFT_PASS, 16'h4444, 4'd0, 4'd4, res, rdo, z, n, lat);
      n_total++; if ({res, rdo} !== {16'h4444, 4'd4}) $display("FAIL flush_next_beat got %h/%0d want 4444/4", res, rdo); else n_pass++;
      n_total++; if (lat !== 2) $display("FAIL flush_next_latency got %0d want 2", lat); else n_pass++;
      // a beat accepted in the flush cycle itself must vanish
      @(negedge clk);
      bus.in_src = 16'h5555; bus.in_rd = 4'd5; bus.in_valid = 1'b1; flush = 1'b1;
      #1;
      n_total++; if (bus.in_ready !== 1'b1) $display("FAIL flush_in_ready got %b want 1", bus.in_ready); else n_pass++;
      @(negedge clk);
      bus.in_valid = 1'b0; flush = 1'b0;
      leaked = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) leaked = 1;
      end
      n_total++; if (leaked !== 1'b0) $display("FAIL flush_accept_leak got %b want 0", leaked); else n_pass++;
   endtask

   task automatic test_mid_reset();
      bit leaked = 0;
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_op = SHIFT_ROR; bus.in_src = 16'h1234; bus.in_amt = 4'd4; bus.in_rd = 4'd9;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_total++; if ({bus.out_valid, bus.out_result, bus.out_rd} !== 21'd0)
         $display("FAIL midrst_outputs got %b/%h/%h want 0/0000/0", bus.out_valid, bus.out_result, bus.out_rd);
      else n_pass++;
      repeat (3) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) leaked = 1;
      end
      n_total++; if (leaked !== 1'b0) $display("FAIL midrst_leak got %b want 0", leaked); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_ror();
      test_sll();
      test_sra();
      test_amt0();
      test_back_to_back();
      test_flush();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
